dac_sample_scheduler: RTL and testbench
=======================================

Name: dac_sample_scheduler

Overview:
- Sequences sample delivery into the segmented thermometer/binary DAC digital interface at a programmable sample rate.
- Buffers samples from the modem datapath in a small FIFO (valid/ready handshake).
- Issues one DAC code per sample tick and drives the DAC randomise enable, changing it only on tick boundaries.
- Handles start-up priming, underrun and graceful shutdown to midscale.

Parameters:
DATA_WIDTH, 10, DAC code width; matches the DAC interface input width
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW
DIV_WIDTH, 8, width of the sample-rate divider
PRIME_LEVEL, 4, FIFO level required before playback starts (1..2**FIFO_AW)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
enable_i  input  1  playback request
div_i  input  DIV_WIDTH  tick period minus one, in clk_i cycles
randomise_req_i  input  1  requested DAC randomisation
s_data_i  input  DATA_WIDTH  sample in
s_valid_i  input  1  sample valid
s_ready_o  output  1  sample accepted when valid&ready
dac_code_o  output  DATA_WIDTH  registered code to the DAC interface
dac_strobe_o  output  1  one-cycle pulse, new code this cycle
randomise_en_o  output  1  DAC randomise enable
state_o  output  2  IDLE=0, PRIME=1, RUN=2, DRAIN=3
underrun_o  output  1  one-cycle pulse, tick with empty FIFO in RUN
fifo_level_o  output  FIFO_AW+1  current FIFO occupancy
underrun_count_o  output  16  see Optional Feature

Behaviour:
- Reset (async, immediate, also mid-operation): state IDLE, FIFO empty, dac_code_o = midscale 2**(DATA_WIDTH-1), all pulses 0, randomise_en_o 0, tick counter 0, underrun_count_o 0.
- s_ready_o = (state != IDLE) && !full, derived from registered level; no bypass. Push when valid&ready.
- IDLE: FIFO held empty; goes to PRIME when enable_i = 1.
- PRIME: accepts samples; goes to RUN when level >= PRIME_LEVEL; goes to IDLE if enable_i = 0.
- Tick counter: cleared on entry to RUN; increments each cycle in RUN/DRAIN; tick when counter == div_i, then clears. Period = div_i+1 cycles; div_i = 0 ticks every cycle. div_i is compared live, so a reduction below the current count takes effect after the counter wraps at 2**DIV_WIDTH.
- On a tick with the FIFO non-empty: pop head to dac_code_o and pulse dac_strobe_o in the cycle the new code is visible.
- On a tick in RUN with the FIFO empty: dac_code_o holds, no strobe, pulse underrun_o; remain in RUN.
- Simultaneous push and pop: both take effect and the level is unchanged. Push into an empty FIFO on a tick does not fall through; that tick counts as an underrun.
- RUN goes to DRAIN when enable_i = 0.
- DRAIN:
  - Pushes still accepted.
  - Ticks pop the FIFO until empty.
  - The first tick with the FIFO empty loads midscale and strobes, with no underrun pulse, then the block returns to IDLE.
  - If enable_i = 1 in DRAIN, return to RUN with no counter clear.
- randomise_en_o is registered from randomise_req_i only on tick cycles and on PRIME->RUN entry; it is forced to 0 in IDLE and PRIME.
- dac_code_o changes only on ticks or reset.

Optional Feature:
- Macro: DAC_UNDERRUN_COUNT_EN.
- Defined: underrun_count_o is a 16-bit counter incremented on each underrun_o pulse, saturating at 16'hFFFF and cleared on the IDLE->PRIME transition.
- Undefined: no counter logic; underrun_count_o is tied to 0.

Test Plan:
- Reset, then enable_i=1, div_i=3, push 4 samples 0x001..0x004 -> PRIME->RUN on the 4th push; strobes every 4 cycles; codes 0x001..0x004 in order; first strobe 4 cycles after RUN entry.
- Stop pushing after 2 samples in RUN with div_i=0 -> 2 strobes, then underrun_o on every following cycle, dac_code_o holds the last code; with the macro, underrun_count_o increments per pulse.
- Fill the FIFO to 8 with s_valid_i held high -> s_ready_o low at level 8; a pop frees one slot and the next push is accepted; no sample lost or duplicated.
- Drop enable_i with 3 samples queued -> DRAIN outputs all 3, then midscale 0x200 with a strobe, state returns to IDLE, no underrun pulse.
- Toggle randomise_req_i between ticks with div_i=7 -> randomise_en_o changes only on strobe/tick cycles; forced 0 after return to IDLE.
- Assert rst_i mid-RUN between clock edges -> outputs reach reset values immediately; enable_i held high -> PRIME re-entered after release.

Source files
------------

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: buffers modem samples in a small FIFO and releases one DAC
// code per programmable sample tick, with priming, underrun and drain-to-midscale.
// Optional feature macro: DAC_UNDERRUN_COUNT_EN (saturating 16-bit underrun counter).
module dac_sample_scheduler #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned PRIME_LEVEL = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  randomise_req_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] dac_code_o,
  output logic                  dac_strobe_o,
  output logic                  randomise_en_o,
  output logic [1:0]            state_o,
  output logic                  underrun_o,
  output logic [FIFO_AW:0]      fifo_level_o,
  output logic [15:0]           underrun_count_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam logic [DATA_WIDTH-1:0] MIDSCALE  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      PRIME_LVL = LVL_W'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] code_q, code_d;
  logic                  strobe_q, strobe_d;
  logic                  underrun_q, underrun_d;
  logic                  rnd_q, rnd_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic active;
  logic empty;
  logic push;
  logic tick;
  logic pop;

  // Ready comes only from registered state and level, never from the incoming valid.
  assign s_ready_o = (state_q != ST_IDLE) && (level_q != FULL_LVL);

  // Next-state, FIFO bookkeeping, tick generation and output staging.
  always_comb begin
    active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    empty      = (level_q == '0);
    push       = s_valid_i && s_ready_o;
    tick       = active && (cnt_q == div_i);
    pop        = tick && !empty;

    state_d    = state_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    code_d     = code_q;
    rnd_d      = rnd_q;
    cnt_d      = '0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (active) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    // A tick either delivers the head sample, flags an underrun, or finishes a drain.
    if (pop) begin
      code_d   = mem_q[rd_ptr_q];
      strobe_d = 1'b1;
    end else if (tick && (state_q == ST_RUN)) begin
      underrun_d = 1'b1;
    end else if (tick) begin
      code_d   = MIDSCALE;
      strobe_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_PRIME;
      ST_PRIME: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (level_d >= PRIME_LVL) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:   if (!enable_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (tick && empty) begin
          state_d = ST_IDLE;
        end else if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // Anything left over when returning to IDLE is discarded.
    if (state_d == ST_IDLE) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    // Randomise enable follows the request only on ticks and on playback start.
    if ((state_d == ST_IDLE) || (state_d == ST_PRIME)) begin
      rnd_d = 1'b0;
    end else if (tick || (state_q == ST_PRIME)) begin
      rnd_d = randomise_req_i;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      code_q     <= MIDSCALE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      rnd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      rnd_q      <= rnd_d;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

`ifdef DAC_UNDERRUN_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun counter, restarted when a new playback session begins.
  always_comb begin
    ucnt_d = ucnt_q;
    if ((state_q == ST_IDLE) && (state_d == ST_PRIME)) begin
      ucnt_d = '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign underrun_count_o = ucnt_q;
`else
  assign underrun_count_o = 16'h0000;
`endif

  assign dac_code_o     = code_q;
  assign dac_strobe_o   = strobe_q;
  assign randomise_en_o = rnd_q;
  assign state_o        = state_q;
  assign underrun_o     = underrun_q;
  assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler: directed scenarios, a queue-based reference model,
// a per-cycle output compare and a few hand-computed literal expectations.
`timescale 1ns/1ps
module tb_dac_sample_scheduler;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int VW    = 8;
  localparam int PL    = 4;
  localparam int DEPTH = 8;
  localparam int MID   = 'h200;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          enable  = 1'b0;
  logic          rreq    = 1'b0;
  logic          s_valid = 1'b0;
  logic [VW-1:0] div     = '0;
  logic [DW-1:0] s_data  = '0;

  logic          s_ready_o;
  logic [DW-1:0] dac_code_o;
  logic          dac_strobe_o;
  logic          randomise_en_o;
  logic [1:0]    state_o;
  logic          underrun_o;
  logic [AW:0]   fifo_level_o;
  logic [15:0]   underrun_count_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int dval;

  dac_sample_scheduler #(
    .DATA_WIDTH (DW),
    .FIFO_AW    (AW),
    .DIV_WIDTH  (VW),
    .PRIME_LEVEL(PL)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .div_i           (div),
    .randomise_req_i (rreq),
    .s_data_i        (s_data),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready_o),
    .dac_code_o      (dac_code_o),
    .dac_strobe_o    (dac_strobe_o),
    .randomise_en_o  (randomise_en_o),
    .state_o         (state_o),
    .underrun_o      (underrun_o),
    .fifo_level_o    (fifo_level_o),
    .underrun_count_o(underrun_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample queue plus scalar state, advanced once per clock.
  int m_state, m_cnt, m_code, m_strobe, m_und, m_rnd, m_ucnt, nxt;
  int mq[$];
  bit do_push, do_tick, was_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_cnt = 0; m_code = MID; m_strobe = 0; m_und = 0; m_rnd = 0; m_ucnt = 0;
      mq.delete();
    end else begin
      do_push   = s_valid && (m_state != 0) && (mq.size() < DEPTH);
      do_tick   = (m_state >= 2) && (m_cnt == int'(div));
      was_empty = (mq.size() == 0);
      m_strobe  = 0;
      m_und     = 0;
      if (do_tick) begin
        if (!was_empty) begin
          m_code = mq.pop_front(); m_strobe = 1;
        end else if (m_state == 2) begin
          m_und = 1;
        end else begin
          m_code = MID; m_strobe = 1;
        end
      end
      if (do_push) mq.push_back(int'(s_data));
      nxt = m_state;
      case (m_state)
        0: if (enable) nxt = 1;
        1: if (!enable) nxt = 0; else if (mq.size() >= PL) nxt = 2;
        2: if (!enable) nxt = 3;
        default: if (do_tick && was_empty) nxt = 0; else if (enable) nxt = 2;
      endcase
      if (m_state >= 2) m_cnt = do_tick ? 0 : (m_cnt + 1) % 256;
      if (nxt < 2 || m_state == 1) m_cnt = 0;
      if (nxt < 2) m_rnd = 0;
      else if (do_tick || m_state == 1) m_rnd = int'(rreq);
`ifdef DAC_UNDERRUN_COUNT_EN
      if (m_state == 0 && nxt == 1) m_ucnt = 0;
      else if (m_und == 1 && m_ucnt < 65535) m_ucnt++;
`endif
      if (nxt == 0) mq.delete();
      m_state = nxt;
    end
  end

  // Compare every output against the model, half a cycle after each edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("state",    int'(state_o),          m_state);
      chk("code",     int'(dac_code_o),       m_code);
      chk("strobe",   int'(dac_strobe_o),     m_strobe);
      chk("underrun", int'(underrun_o),       m_und);
      chk("rnd_en",   int'(randomise_en_o),   m_rnd);
      chk("level",    int'(fifo_level_o),     mq.size());
      chk("ready",    int'(s_ready_o),        int'((m_state != 0) && (mq.size() < DEPTH)));
      chk("ucount",   int'(underrun_count_o), m_ucnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_one(input int d);
    bit acc;
    acc     = 1'b0;
    s_data  = DW'(d);
    s_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = s_ready_o;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("push_accept", int'(acc), 1);
  endtask

  task automatic pump_cycle();
    bit acc;
    @(negedge clk); acc = s_valid && s_ready_o;
    @(posedge clk); #1;
    if (acc) begin
      dval++;
      s_data = DW'(dval);
    end
  endtask

  initial begin
    bit seen;
    bit und_seen;
    bit prev_rnd;
    int nstb;
    int codes[4];

    // Reset values
    cyc(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_code",  int'(dac_code_o), 'h200);
    chk("rst_level", int'(fifo_level_o), 0);
    chk("rst_ready", int'(s_ready_o), 0);
    chk("rst_rnd",   int'(randomise_en_o), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Priming and first playback at div=3
    enable = 1'b1; div = 8'd3;
    cyc(1);
    chk("prime_entry", int'(state_o), 1);
    for (int i = 1; i <= 4; i++) push_one(i);
    chk("run_entry", int'(state_o), 2);
    cyc(3);
    chk("no_early_strobe", int'(dac_strobe_o), 0);
    cyc(1);
    chk("first_strobe", int'(dac_strobe_o), 1);
    chk("first_code", int'(dac_code_o), 'h001);
    for (int i = 2; i <= 4; i++) begin
      cyc(4);
      chk("seq_strobe", int'(dac_strobe_o), 1);
      chk("seq_code", int'(dac_code_o), i);
    end

    // div=0 with a short burst, then continuous underrun
    div = 8'd0;
    push_one('h010);
    chk("push_empty_underrun", int'(underrun_o), 1);
    push_one('h011);
    chk("burst_code0", int'(dac_code_o), 'h010);
    cyc(1);
    chk("burst_code1", int'(dac_code_o), 'h011);
    cyc(4);
    chk("underrun_hold", int'(underrun_o), 1);
    chk("underrun_code", int'(dac_code_o), 'h011);

    // Fill to full with valid held high, then one pop and one refill
    div = 8'd200;
    dval = 'h100; s_data = DW'(dval); s_valid = 1'b1;
    for (int i = 0; i < 12; i++) pump_cycle();
    chk("full_level", int'(fifo_level_o), 8);
    chk("full_ready", int'(s_ready_o), 0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      pump_cycle();
      seen = dac_strobe_o;
    end
    chk("full_pop_seen", int'(seen), 1);
    chk("full_pop_code", int'(dac_code_o), 'h100);
    chk("full_pop_level", int'(fifo_level_o), 7);
    pump_cycle();
    s_valid = 1'b0;
    chk("refill_level", int'(fifo_level_o), 8);
    chk("push_count", dval, 'h109);

    // Drain with three samples left
    div = 8'd3;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc(1);
      seen = dac_strobe_o && (fifo_level_o == 4'd3);
    end
    chk("drain_setup", int'(seen), 1);
    enable = 1'b0;
    nstb = 0; und_seen = 1'b0;
    for (int i = 0; i < 100 && state_o != 2'd0; i++) begin
      cyc(1);
      if (dac_strobe_o) begin
        if (nstb < 4) codes[nstb] = int'(dac_code_o);
        nstb++;
      end
      if (underrun_o) und_seen = 1'b1;
    end
    chk("drain_idle", int'(state_o), 0);
    chk("drain_strobes", nstb, 4);
    chk("drain_code0", codes[0], 'h106);
    chk("drain_code1", codes[1], 'h107);
    chk("drain_code2", codes[2], 'h108);
    chk("drain_mid", codes[3], 'h200);
    chk("drain_no_underrun", int'(und_seen), 0);

    // Randomise enable updates only on ticks
    rreq = 1'b1; enable = 1'b1; div = 8'd7;
    cyc(1);
    chk("rnd_prime", int'(randomise_en_o), 0);
    for (int i = 0; i < 4; i++) push_one('h020 + i);
    chk("rnd_run_entry", int'(randomise_en_o), 1);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) rreq = ~rreq;
      prev_rnd = randomise_en_o;
      cyc(1);
      if (randomise_en_o != prev_rnd)
        chk("rnd_change_on_tick", int'(dac_strobe_o | underrun_o), 1);
    end
    enable = 1'b0;
    for (int i = 0; i < 100 && state_o != 2'd0; i++) cyc(1);
    chk("rnd_idle_state", int'(state_o), 0);
    chk("rnd_idle", int'(randomise_en_o), 0);

    // Asynchronous reset in the middle of RUN
    enable = 1'b1; div = 8'd2;
    cyc(1);
    for (int i = 0; i < 6; i++) push_one('h030 + i);
    cyc(2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_state",  int'(state_o), 0);
    chk("arst_code",   int'(dac_code_o), 'h200);
    chk("arst_strobe", int'(dac_strobe_o), 0);
    chk("arst_level",  int'(fifo_level_o), 0);
    chk("arst_ready",  int'(s_ready_o), 0);
    chk("arst_rnd",    int'(randomise_en_o), 0);
    chk("arst_ucnt",   int'(underrun_count_o), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_reprime", int'(state_o), 1);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
